// File: rtl/stoch_result_framer.sv
`default_nettype none
// ============================================================================
// Module   : stoch_result_framer
// Purpose  : Serialises the three stochastic-unit averages into a start/stop
//            framed bit stream with ready/valid handshake, a one-deep holding
//            register for back-to-back epochs and an inter-frame idle gap.
//            Optional even parity per word: define STOCH_FRAMER_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module stoch_result_framer #(
    parameter int GAP_BITS = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       epoch,
    input  logic [8:0] mul_avg,
    input  logic [8:0] add_avg,
    input  logic [8:0] smul_avg,
    input  logic       tx_ready,
    input  logic       ovr_clr,
    output logic       tx_valid,
    output logic       tx_bit,
    output logic       tx_sof,
    output logic       busy,
    output logic       overrun,
    output logic [7:0] frame_cnt
);

`ifdef STOCH_FRAMER_PARITY_EN
    localparam int c_data_len = 30;
`else
    localparam int c_data_len = 27;
`endif
    localparam logic [4:0] c_last_cnt = 5'(c_data_len);
    localparam logic [3:0] c_gap_load = 4'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_STOP  = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [c_data_len-1:0]   shreg_q, shreg_d;
    logic [c_data_len-1:0]   hold_q, hold_d;
    logic                    hold_vld_q, hold_vld_d;
    logic [4:0]              bit_cnt_q, bit_cnt_d;
    logic [3:0]              gap_cnt_q, gap_cnt_d;
    logic                    overrun_q, overrun_d;
    logic [7:0]              frame_cnt_q, frame_cnt_d;
    logic [c_data_len-1:0]   w_payload;
    logic                    w_xfer;

    // Transmission order is LSB of the packed vector first.
    always_comb begin
`ifdef STOCH_FRAMER_PARITY_EN
        w_payload = {^smul_avg, smul_avg, ^add_avg, add_avg, ^mul_avg, mul_avg};
`else
        w_payload = {smul_avg, add_avg, mul_avg};
`endif
    end

    always_comb begin
        tx_valid  = (state_q == ST_SHIFT) || (state_q == ST_STOP);
        tx_sof    = (state_q == ST_SHIFT) && (bit_cnt_q == 5'd0);
        tx_bit    = 1'b0;
        if (state_q == ST_SHIFT) begin
            tx_bit = (bit_cnt_q == 5'd0) ? 1'b1 : shreg_q[0];
        end
        busy      = (state_q != ST_IDLE);
        overrun   = overrun_q;
        frame_cnt = frame_cnt_q;
    end

    assign w_xfer = tx_valid & tx_ready;

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        hold_d      = hold_q;
        hold_vld_d  = hold_vld_q;
        bit_cnt_d   = bit_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        overrun_d   = overrun_q;
        frame_cnt_d = frame_cnt_q;

        if (ovr_clr) begin
            overrun_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                // Held data is older than a same-cycle epoch, so it goes first
                // and the new snapshot takes its place in the holding register.
                if (hold_vld_q) begin
                    shreg_d    = hold_q;
                    bit_cnt_d  = 5'd0;
                    state_d    = ST_SHIFT;
                    hold_vld_d = epoch;
                    if (epoch) begin
                        hold_d = w_payload;
                    end
                end else if (epoch) begin
                    shreg_d   = w_payload;
                    bit_cnt_d = 5'd0;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_xfer) begin
                    if (bit_cnt_q != 5'd0) begin
                        shreg_d = shreg_q >> 1;
                    end
                    if (bit_cnt_q == c_last_cnt) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
            end
            ST_STOP: begin
                if (w_xfer) begin
                    frame_cnt_d = frame_cnt_q + 8'd1;
                    gap_cnt_d   = c_gap_load;
                    state_d     = (GAP_BITS == 0) ? ST_IDLE : ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == 4'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (epoch && (state_q != ST_IDLE)) begin
            hold_d     = w_payload;
            hold_vld_d = 1'b1;
            if (hold_vld_q) begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q     <= ST_IDLE;
            shreg_q     <= '0;
            hold_q      <= '0;
            hold_vld_q  <= 1'b0;
            bit_cnt_q   <= 5'd0;
            gap_cnt_q   <= 4'd0;
            overrun_q   <= 1'b0;
            frame_cnt_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            hold_q      <= hold_d;
            hold_vld_q  <= hold_vld_d;
            bit_cnt_q   <= bit_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            overrun_q   <= overrun_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stoch_result_framer.sv
`default_nettype none
// ============================================================================
// Module   : tb_stoch_result_framer
// Purpose  : Self-checking bench: hand-written frame table, directed
//            multi-cycle sequences and a bit-queue reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stoch_result_framer;

    localparam int GAP = 2;
`ifdef STOCH_FRAMER_PARITY_EN
    localparam int C_LEN = 32;
    localparam bit C_PAR = 1'b1;
`else
    localparam int C_LEN = 29;
    localparam bit C_PAR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       epoch = 1'b0;
    logic [8:0] mul_avg = '0, add_avg = '0, smul_avg = '0;
    logic       tx_ready = 1'b1;
    logic       ovr_clr = 1'b0;
    logic       tx_valid, tx_bit, tx_sof, busy, overrun;
    logic [7:0] frame_cnt;

    stoch_result_framer #(.GAP_BITS(GAP)) dut (
        .clk(clk), .rst_n(rst_n), .epoch(epoch),
        .mul_avg(mul_avg), .add_avg(add_avg), .smul_avg(smul_avg),
        .tx_ready(tx_ready), .ovr_clr(ovr_clr),
        .tx_valid(tx_valid), .tx_bit(tx_bit), .tx_sof(tx_sof),
        .busy(busy), .overrun(overrun), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int ntests = 0;
    int nfail  = 0;
    int cyc    = 0;
    bit cap[$];

    // Reference model: the frame still to be sent is a plain queue of bits.
    bit          mq[$];
    int          m_gap = 0;
    logic [26:0] m_hold = '0;
    bit          m_hold_vld = 0;
    bit          m_ovr = 0;
    logic [7:0]  m_cnt = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_str(input string name, input string act, input string exp);
        ntests++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %s expected %s", name, act, exp);
        end
    endtask

    function automatic string frame_str(input logic [8:0] m, input logic [8:0] a, input logic [8:0] s);
        logic [8:0] w[3];
        string r;
        w = '{m, a, s};
        r = "1";
        for (int i = 0; i < 3; i++) begin
            for (int b = 0; b < 9; b++) r = $sformatf("%s%0d", r, w[i][b]);
            if (C_PAR) r = $sformatf("%s%0d", r, ^w[i]);
        end
        return {r, "0"};
    endfunction

    function automatic string cap_str();
        string r = "";
        foreach (cap[i]) r = $sformatf("%s%0d", r, cap[i]);
        return r;
    endfunction

    function automatic string fr(input string st, input string w0, input string w1,
                                 input string w2, input string sp);
        return {st, w0, w1, w2, sp};
    endfunction

    task automatic load_frame(input logic [26:0] d);
        logic [8:0] w;
        mq.push_back(1'b1);
        for (int i = 0; i < 3; i++) begin
            w = d[i*9 +: 9];
            for (int b = 0; b < 9; b++) mq.push_back(w[b]);
            if (C_PAR) mq.push_back(^w);
        end
        mq.push_back(1'b0);
    endtask

    task automatic model_step();
        bit was_idle;
        logic [26:0] d;
        d = {smul_avg, add_avg, mul_avg};
        if (rst_n) begin
            mq.delete(); m_gap = 0; m_hold_vld = 0; m_ovr = 0; m_cnt = '0;
        end else begin
            was_idle = (mq.size() == 0) && (m_gap == 0);
            if (ovr_clr) m_ovr = 0;
            if (was_idle) begin
                if (m_hold_vld) begin
                    load_frame(m_hold);
                    m_hold_vld = 0;
                    if (epoch) begin m_hold = d; m_hold_vld = 1; end
                end else if (epoch) begin
                    load_frame(d);
                end
            end else begin
                if (mq.size() != 0) begin
                    if (tx_ready) begin
                        void'(mq.pop_front());
                        if (mq.size() == 0) begin m_cnt++; m_gap = GAP; end
                    end
                end else begin
                    m_gap--;
                end
                if (epoch) begin
                    if (m_hold_vld) m_ovr = 1;
                    m_hold = d; m_hold_vld = 1;
                end
            end
        end
    endtask

    task automatic check_cycle();
        bit ev;
        ev = (mq.size() != 0);
        chk("cycle_outputs",
            {19'd0, tx_valid, tx_valid ? tx_bit : 1'b0, tx_sof, busy, overrun, frame_cnt},
            {19'd0, ev, ev ? mq[0] : 1'b0, mq.size() == C_LEN, !((mq.size() == 0) && (m_gap == 0)),
             m_ovr, m_cnt});
    endtask

    // One clock: record a transfer, advance the model at the edge, compare at the falling edge.
    task automatic tick();
        if (tx_valid === 1'b1 && tx_ready) cap.push_back(tx_bit);
        @(posedge clk);
        model_step();
        cyc++;
        @(negedge clk);
        check_cycle();
    endtask

    task automatic wait_idle();
        tx_ready = 1'b1; epoch = 1'b0;
        for (int k = 0; k < 300 && busy !== 1'b0; k++) tick();
        chk("wait_idle", busy, 0);
    endtask

    task automatic send_frame(input logic [8:0] m, input logic [8:0] a, input logic [8:0] s,
                              input bit toggle, output string got, output int vcyc,
                              output logic [2:0] lat, output bit stall_ok);
        bit pr, pb, ps;
        wait_idle();
        cap.delete();
        mul_avg = m; add_avg = a; smul_avg = s; epoch = 1'b1; tx_ready = 1'b1;
        tick();
        epoch = 1'b0;
        lat = {tx_valid, tx_sof, tx_bit};
        vcyc = 0; stall_ok = 1; pr = 1; pb = 0; ps = 0;
        for (int k = 0; k < 300 && cap.size() < C_LEN; k++) begin
            tx_ready = toggle ? (k % 2 == 0) : 1'b1;
            if (tx_valid) vcyc++;
            if (!pr && (tx_bit !== pb || tx_sof !== ps || tx_valid !== 1'b1)) stall_ok = 0;
            pr = tx_ready; pb = tx_bit; ps = tx_sof;
            tick();
        end
        tx_ready = 1'b1;
        got = cap_str();
    endtask

    typedef struct {
        logic [8:0] mul;
        logic [8:0] add;
        logic [8:0] smul;
        string      exp;
    } vec_t;
    vec_t vt[4];

    initial begin : main
        string       got;
        int          vc, gapc, s_edge, sof_edge;
        logic [2:0]  lat;
        bit          sok, sent, got_stop, got_sof;
        logic [7:0]  c0;
        logic [8:0]  r0, r1, r2;

`ifdef STOCH_FRAMER_PARITY_EN
        vt[0] = '{9'h155, 9'h0AA, 9'h1FF, fr("1", "1010101011", "0101010100", "1111111111", "0")};
        vt[1] = '{9'h001, 9'h003, 9'h000, fr("1", "1000000001", "1100000000", "0000000000", "0")};
        vt[2] = '{9'h100, 9'h000, 9'h0F0, fr("1", "0000000011", "0000000000", "0000111100", "0")};
        vt[3] = '{9'h000, 9'h000, 9'h000, fr("1", "0000000000", "0000000000", "0000000000", "0")};
`else
        vt[0] = '{9'h155, 9'h0AA, 9'h1FF, fr("1", "101010101", "010101010", "111111111", "0")};
        vt[1] = '{9'h001, 9'h003, 9'h000, fr("1", "100000000", "110000000", "000000000", "0")};
        vt[2] = '{9'h100, 9'h000, 9'h0F0, fr("1", "000000001", "000000000", "000011110", "0")};
        vt[3] = '{9'h000, 9'h000, 9'h000, fr("1", "000000000", "000000000", "000000000", "0")};
`endif

        // Reset state
        rst_n = 1'b1; epoch = 1'b1;
        tick(); tick();
        rst_n = 1'b0; epoch = 1'b0;
        chk("reset_outputs", {tx_valid, tx_bit, tx_sof, busy, overrun, frame_cnt}, 13'd0);

        // Frame table with tx_ready held high
        for (int i = 0; i < 4; i++) begin
            c0 = frame_cnt;
            send_frame(vt[i].mul, vt[i].add, vt[i].smul, 1'b0, got, vc, lat, sok);
            chk_str($sformatf("frame_vec%0d", i), got, vt[i].exp);
            chk($sformatf("latency_vec%0d", i), lat, 3'b111);
            chk($sformatf("frame_cnt_vec%0d", i), frame_cnt, c0 + 8'd1);
            gapc = 0;
            for (int k = 0; k < 6; k++) begin
                if (busy && !tx_valid) gapc++;
                tick();
            end
            chk($sformatf("gap_len_vec%0d", i), gapc, GAP);
        end

        // Backpressure: ready toggles every cycle
        send_frame(9'h155, 9'h0AA, 9'h1FF, 1'b1, got, vc, lat, sok);
        chk_str("bp_frame", got, vt[0].exp);
        chk("bp_stall_stable", sok, 1);
        chk("bp_valid_cycles", vc, 2 * C_LEN - 1);

        // Queueing: second epoch while bit 10 is on the line
        wait_idle(); cap.delete();
        mul_avg = 9'h0C3; add_avg = 9'h11F; smul_avg = 9'h07E; epoch = 1'b1;
        tick(); epoch = 1'b0;
        sent = 0; got_stop = 0; got_sof = 0; s_edge = 0; sof_edge = 0;
        for (int k = 0; k < 200 && !got_sof; k++) begin
            epoch = 1'b0;
            if (!sent && cap.size() == 10) begin
                mul_avg = 9'h1A5; add_avg = 9'h05A; smul_avg = 9'h133; epoch = 1'b1; sent = 1;
            end
            if (got_stop && tx_sof) begin got_sof = 1; sof_edge = cyc; cap.delete(); end
            if (!got_stop && tx_valid && tx_ready && cap.size() == C_LEN - 1) begin
                got_stop = 1; s_edge = cyc + 1;
            end
            if (!got_sof) tick();
        end
        epoch = 1'b0;
        chk("queue_second_started", got_sof, 1);
        chk("queue_start_delay", sof_edge - s_edge, GAP + 1);
        chk("queue_overrun", overrun, 0);
        for (int k = 0; k < 100 && cap.size() < C_LEN; k++) tick();
        chk_str("queue_frame2", cap_str(), frame_str(9'h1A5, 9'h05A, 9'h133));

        // Overrun: three epochs in one frame, the third snapshot wins
        wait_idle(); cap.delete();
        mul_avg = 9'h011; add_avg = 9'h022; smul_avg = 9'h033; epoch = 1'b1;
        tick(); epoch = 1'b0;
        for (int k = 0; k < 100 && cap.size() < C_LEN; k++) begin
            epoch = 1'b0;
            if (k == 5)  begin mul_avg = 9'h0AB; add_avg = 9'h0CD; smul_avg = 9'h0EF; epoch = 1'b1; end
            if (k == 12) begin mul_avg = 9'h1E1; add_avg = 9'h0D2; smul_avg = 9'h1C3; epoch = 1'b1; end
            tick();
        end
        epoch = 1'b0;
        chk("ovr_set", overrun, 1);
        for (int k = 0; k < 20 && !tx_sof; k++) tick();
        cap.delete();
        for (int k = 0; k < 100 && cap.size() < C_LEN; k++) tick();
        chk_str("ovr_frame2", cap_str(), frame_str(9'h1E1, 9'h0D2, 9'h1C3));
        chk("ovr_still_set", overrun, 1);
        ovr_clr = 1'b1; tick(); ovr_clr = 1'b0;
        chk("ovr_cleared", overrun, 0);

        // Reset at bit 15 with an epoch in the same cycle
        wait_idle(); cap.delete();
        mul_avg = 9'h0F0; add_avg = 9'h00F; smul_avg = 9'h1AA; epoch = 1'b1;
        tick(); epoch = 1'b0;
        for (int k = 0; k < 100 && cap.size() < 15; k++) tick();
        rst_n = 1'b1; epoch = 1'b1;
        tick();
        rst_n = 1'b0; epoch = 1'b0;
        chk("rst_mid_outputs", {tx_valid, busy, frame_cnt}, 10'd0);
        tick(); tick();
        chk("rst_epoch_ignored", busy, 0);
        send_frame(9'h155, 9'h0AA, 9'h1FF, 1'b0, got, vc, lat, sok);
        chk_str("rst_after_frame", got, vt[0].exp);
        chk("rst_after_cnt", frame_cnt, 1);

        // Dense epochs with ready high: drives frame_cnt through its wrap
        for (int k = 0; k < 9500; k++) begin
            epoch = ($urandom_range(0, 1) == 0);
            mul_avg = 9'($urandom); add_avg = 9'($urandom); smul_avg = 9'($urandom);
            tx_ready = 1'b1;
            ovr_clr = ($urandom_range(0, 15) == 0);
            tick();
        end

        // General random traffic including occasional resets
        for (int k = 0; k < 4000; k++) begin
            epoch = ($urandom_range(0, 29) == 0);
            mul_avg = 9'($urandom); add_avg = 9'($urandom); smul_avg = 9'($urandom);
            tx_ready = ($urandom_range(0, 3) != 0);
            ovr_clr = ($urandom_range(0, 63) == 0);
            rst_n = ($urandom_range(0, 999) == 0);
            tick();
        end
        rst_n = 1'b0; epoch = 1'b0; ovr_clr = 1'b0;

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stoch_result_framer.md
STOCH_RESULT_FRAMER -- requirements
Module: stoch_result_framer

Interface
REQ-001 Parameter: GAP_BITS, default 2, number of idle cycles (tx_valid low) forced between frames; legal range 0..15.
REQ-002 Port: clk  in  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst_n  in  1  reset, synchronous, active-high (1 = reset), sampled on the rising edge of clk.
REQ-004 Port: epoch  in  1  one-cycle pulse when the global 2^17+1-cycle accumulation window wraps.
REQ-005 Port: mul_avg  in  9  multiplier average, valid in the cycle epoch is high.
REQ-006 Port: add_avg  in  9  adder average, valid in the cycle epoch is high.
REQ-007 Port: smul_avg  in  9  self-multiplier average, valid in the cycle epoch is high.
REQ-008 Port: tx_ready  in  1  downstream accepts the current bit.
REQ-009 Port: ovr_clr  in  1  clears the overrun flag.
REQ-010 Port: tx_valid  out  1  tx_bit is valid.
REQ-011 Port: tx_bit  out  1  serial frame bit.
REQ-012 Port: tx_sof  out  1  high while tx_bit is the start bit.
REQ-013 Port: busy  out  1  frame in progress or gap running.
REQ-014 Port: overrun  out  1  sticky flag: a snapshot was lost.
REQ-015 Port: frame_cnt  out  8  count of completed frames, wraps 255->0.

Function
REQ-016 Frame order: start bit (1), mul_avg[0..8], add_avg[0..8], smul_avg[0..8] (each word LSB first), stop bit (0); 29 bits without parity.
REQ-017 States: IDLE, SHIFT, STOP, GAP.
- IDLE -> SHIFT when a snapshot is pending.
- SHIFT -> STOP after the last data/parity bit is accepted.
- STOP -> GAP when the stop bit is accepted (GAP_BITS=0: STOP -> IDLE).
- GAP -> IDLE after GAP_BITS cycles.
REQ-018 On epoch, the three inputs are captured into a 27-bit snapshot in the same edge.
REQ-019 Latency: with the block in IDLE and epoch at edge N, tx_valid=1, tx_sof=1 and tx_bit=1 from edge N+1.
REQ-020 A bit transfers only on an edge where tx_valid and tx_ready are both 1; the next bit appears from the following cycle.
REQ-021 While tx_valid=1 and tx_ready=0, tx_bit and tx_sof hold stable; tx_valid does not drop.
REQ-022 tx_valid=0 in IDLE and GAP.
REQ-023 Epoch while busy: the snapshot goes to a one-deep holding register.
- Holding empty: the frame following the current one transmits the held data after the gap.
- Holding already full: overwrite it with the newest data and set overrun.
REQ-024 Epoch in the same cycle the stop bit is accepted is treated as epoch-while-busy; it is never dropped.
REQ-025 overrun clears on ovr_clr=1; simultaneous set and ovr_clr leaves overrun=1 (set wins).
REQ-026 frame_cnt increments on the edge the stop bit is accepted.
REQ-027 busy=1 in SHIFT, STOP and GAP; busy=0 in IDLE.

Reset
REQ-028 While rst_n=1 at an edge, the block enters IDLE and clears the snapshot and holding register, the holding-valid flag and the gap counter.
REQ-029 While rst_n=1 at an edge, outputs become: tx_valid=0, tx_bit=0, tx_sof=0, busy=0, overrun=0, frame_cnt=0.
REQ-030 Reset mid-frame aborts the frame with no stop bit; epoch during reset is ignored.

Configuration
REQ-031 Macro STOCH_FRAMER_PARITY_EN defined: each 9-bit word is followed by one even-parity bit (XOR of its 9 bits); frame length 32 bits.
REQ-032 Macro STOCH_FRAMER_PARITY_EN undefined: no parity bits and no parity logic; frame length 29 bits.

Verification
REQ-033 Idle frame, parity off, tx_ready=1: epoch with mul=0x155, add=0x0AA, smul=0x1FF -> 29 bits, namely 1, 101010101, 010101010, 111111111, 0; frame_cnt=1; tx_valid=0 for 2 cycles after the stop bit.
REQ-034 Backpressure: same data, tx_ready toggled 1/0 every cycle -> identical bit sequence; tx_bit stable in every tx_ready=0 cycle; frame takes 57 cycles.
REQ-035 Queueing: second epoch at bit 10 -> second frame starts exactly GAP_BITS+1 cycles after the first stop bit is accepted; overrun=0.
REQ-036 Overrun: three epochs within one frame -> overrun=1, second frame carries the third snapshot; ovr_clr pulse -> overrun=0.
REQ-037 Parity on: mul=0x001, add=0x003, smul=0x000 -> parity bits 1, 0, 0; 32-bit frame.
REQ-038 Reset at bit 15 -> next cycle tx_valid=0, busy=0, frame_cnt unchanged from 0; subsequent epoch sends a full frame.
